// File: rtl/req_encoder4to2.sv
// Sequential multi-hot to binary index encoder: captures a request vector, then
// streams the index of each set bit. Define REQ_ENC_MSB_FIRST_EN to serve highest bit first.
module req_encoder4to2 #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       pending_q, pending_d;
  logic [IDX_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_err_q, zero_err_d;
  logic [N-1:0]       remaining;

  // Index of the next bit to serve; the last hit in the scan wins.
  function automatic logic [IDX_W-1:0] pick_idx(input logic [N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
`ifdef REQ_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`endif
    return idx;
  endfunction

  assign in_ready = en && (state_q == IDLE) && !rst;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    zero_err_d  = 1'b0;
    remaining   = pending_q;
    remaining[out_q] = 1'b0;

    if (!en) begin
      // Abort wins over any concurrent output handshake; out keeps its value.
      state_d     = IDLE;
      pending_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in != '0) begin
              state_d     = SERVE;
              pending_d   = in;
              out_d       = pick_idx(in);
              out_valid_d = 1'b1;
            end else begin
              zero_err_d  = 1'b1;
            end
          end
        end
        SERVE: begin
          if (out_valid_q && out_ready) begin
            pending_d = remaining;
            if (remaining != '0) begin
              out_d = pick_idx(remaining);
            end else begin
              out_valid_d = 1'b0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_err_q  <= zero_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_req_encoder4to2.sv
// Self-checking bench for req_encoder4to2: directed test-plan scenarios plus
// randomized traffic, all checked against a queue-based reference model.
module tb_req_encoder4to2;

`ifdef REQ_ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       zero_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of indices still to be emitted, in service order.
  int q[$];
  int last_out = 0;
  int exp_zero = 0;
  int got[$];

  req_encoder4to2 #(.N(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_step();
    int nz;
    nz = 0;
    if (!en) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (in_valid) begin
        if (in != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            int b;
            b = MSB_FIRST ? 3 - k : k;
            if (in[b]) q.push_back(b);
          end
          last_out = q[0];
        end else begin
          nz = 1;
        end
      end
    end else if (out_ready) begin
      void'(q.pop_front());
      if (q.size() != 0) last_out = q[0];
    end
    exp_zero = nz;
  endtask

  task automatic cycle(input logic en_i, input logic [3:0] in_i,
                       input logic iv_i, input logic ordy_i);
    @(negedge clk);
    en        = en_i;
    in        = in_i;
    in_valid  = iv_i;
    out_ready = ordy_i;
    #1;
    check("in_ready",  in_ready,  (en && q.size() == 0) ? 1 : 0);
    check("out_valid", out_valid, (q.size() != 0) ? 1 : 0);
    check("out",       out,       last_out);
    check("zero_err",  zero_err,  exp_zero);
    if (en && out_valid && out_ready) got.push_back(int'(out));
    model_step();
  endtask

  // Pulse rst between edges; the outputs must clear without any clock edge.
  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in = 4'b0000;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out",       out,       0);
    check("rst_zero_err",  zero_err,  0);
    check("rst_in_ready",  in_ready,  0);
    #1;
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    q.delete();
    last_out = 0;
    exp_zero = 0;
    model_step();
  endtask

  task automatic expect_seq(input string tag, input int n, input int e[4]);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check({tag, "_idx"}, got[i], e[i]);
    got.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    int e[4];
    rst = 1'b1; en = 1'b0; in = 4'b0000; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Multi-hot streaming.
    got.delete();
    cycle(1'b1, 4'b1011, 1'b1, 1'b1);
    idle_cycles(5);
    e = MSB_FIRST ? '{3, 1, 0, 0} : '{0, 1, 3, 0};
    expect_seq("multi_1011", 3, e);

    // Backpressure with ignored in_valid pulses during service.
    cycle(1'b1, 4'b0110, 1'b1, 1'b0);
    cycle(1'b1, 4'b1111, 1'b1, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(1'b1, 4'b1001, 1'b1, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0, 1'b1);
    cycle(1'b1, 4'b0000, 1'b0, 1'b1);
    idle_cycles(2);
    e = MSB_FIRST ? '{2, 1, 0, 0} : '{1, 2, 0, 0};
    expect_seq("backpressure", 2, e);

    // Zero vector, then a single-hot vector.
    cycle(1'b1, 4'b0000, 1'b1, 1'b1);
    cycle(1'b1, 4'b0000, 1'b0, 1'b1);
    check("zero_pulse", zero_err, 1);
    cycle(1'b1, 4'b1000, 1'b1, 1'b1);
    idle_cycles(3);
    e = '{3, 0, 0, 0};
    expect_seq("after_zero", 1, e);

    // Abort after the first transfer.
    cycle(1'b1, 4'b1111, 1'b1, 1'b1);
    cycle(1'b1, 4'b0000, 1'b0, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0, 1'b1);
    idle_cycles(3);
    e = MSB_FIRST ? '{3, 0, 0, 0} : '{0, 0, 0, 0};
    expect_seq("abort", 1, e);
    cycle(1'b1, 4'b0001, 1'b1, 1'b1);
    idle_cycles(3);
    e = '{0, 0, 0, 0};
    expect_seq("post_abort", 1, e);

    // Exhaustive single-hot.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = 4'b0001 << i;
      cycle(1'b1, v, 1'b1, 1'b1);
      cycle(1'b1, 4'b0000, 1'b0, 1'b1);
      check("onehot_latency", out_valid, 1);
      idle_cycles(2);
      e = '{i, 0, 0, 0};
      expect_seq("onehot", 1, e);
    end

    // Reset asserted mid-service; nothing from the old vector may follow.
    cycle(1'b1, 4'b1111, 1'b1, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0, 1'b1);
    do_reset();
    got.delete();
    idle_cycles(3);
    check("rst_no_residue", got.size(), 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 19) != 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/req_encoder4to2.md
Name: req_encoder4to2

Overview:
- Sequential one-hot/multi-hot to binary index encoder. Inverse of the team's 2-to-4 decoder.
- Captures a request vector through a valid/ready handshake, then emits the binary index of each set bit, one per output handshake.
- Sits between request sources (interrupt lines, grant vectors) and logic that consumes a binary index.

Parameters:
- N, 4, request vector width.
- IDX_W, 2, index width; must equal clog2(N); N=4/IDX_W=2 is the verified configuration.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low aborts and blocks capture.
- in  input  N  request vector.
- in_valid  input  1  in is valid this cycle.
- in_ready  output  1  block can capture in this cycle.
- out  output  IDX_W  binary index of the current request bit.
- out_valid  output  1  out is valid.
- out_ready  input  1  consumer accepts out this cycle.
- zero_err  output  1  one-cycle pulse: an all-zero vector was captured.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, pending=0, out=0, out_valid=0, zero_err=0.
  - in_ready=0 while rst is high.
- Signal rules:
  - in_ready = en && state==IDLE && !rst. It is combinational.
  - out, out_valid and zero_err are registered.
- IDLE:
  - Capture occurs at a rising edge when in_valid && in_ready.
  - If in != 0: pending <= in, state <= SERVE, out <= index of lowest set bit of in, out_valid <= 1. Latency from capture edge to out_valid high is 1 edge.
  - If in == 0: pending is unchanged, state stays IDLE, zero_err <= 1 for exactly one cycle, out_valid stays 0.
  - No capture means no state change, and zero_err <= 0.
- SERVE:
  - in_ready=0. Any in_valid is ignored, with no capture.
  - out and out_valid hold stable while out_valid && !out_ready.
  - On out_valid && out_ready, the served bit is cleared in pending:
    - If the remaining pending is nonzero: out <= index of its lowest set bit, out_valid stays 1. There are no bubbles, so back-to-back transfers run at 1 per cycle.
    - If the remaining pending is zero: out_valid <= 0, state <= IDLE. in_ready rises in the following cycle, so there is 1 idle cycle between vectors.
  - out holds its last value when out_valid=0.
- en low:
  - In any state, en=0 at an edge sets pending <= 0, out_valid <= 0, state <= IDLE.
  - out keeps its last value.
  - No capture while en=0.
  - en=0 takes priority over a simultaneous out handshake; that transfer is dropped.
- Boundary conditions:
  - in=4'b1111 gives 4 transfers: 0,1,2,3.
  - A single-bit in gives exactly 1 transfer.
  - Bit order within one vector is strictly ascending index.
  - rst asserted mid-SERVE clears everything immediately (async). No partial output follows rst deassertion.
- State encoding is 1 bit (IDLE=0, SERVE=1). Illegal states do not exist.

Optional Feature:
- Macro: REQ_ENC_MSB_FIRST_EN.
- Defined: "lowest set bit" is replaced by "highest set bit" everywhere. in=4'b1011 serves 3,1,0.
- Undefined: LSB-first as above. in=4'b1011 serves 0,1,3.
- Handshake, latency and zero_err are identical in both builds.

Test Plan:
- Reset / idle: rst=1 mid-stream, then release with en=1 -> out_valid=0, zero_err=0, out=0, in_ready=1 on the first cycle after release.
- Multi-hot streaming: in=4'b1011, in_valid=1 for 1 cycle, out_ready=1 -> out=0,1,3 on 3 consecutive cycles with out_valid=1, then out_valid=0 and in_ready=1 one cycle later. With MSB_FIRST: 3,1,0.
- Backpressure: in=4'b0110, out_ready=0 for 3 cycles then 1 -> out=1 held stable with out_valid=1 for 4 cycles, then out=2 for 1 cycle, then out_valid=0. in_valid is pulsed during SERVE and must not be captured.
- Zero vector: in=4'b0000 captured -> zero_err=1 for exactly 1 cycle, out_valid stays 0, state stays IDLE, next vector 4'b1000 -> out=3.
- Abort: in=4'b1111 captured, en=0 after the first transfer -> out_valid=0 next edge, no further indices. With en=1 again, in=4'b0001 -> out=0 only.
- Exhaustive single-hot: each of 4'b0001..4'b1000 with out_ready=1 -> out equals bit index, exactly 1 transfer each, 1-edge latency.
